// File: rtl/cell_mem_pkg.sv
// Shared types for the cell-state RAM arbiter: requester tags and the
// registered RAM request word.
package cell_mem_pkg;

    localparam int CM_ADDR_W = 16;
    localparam int CM_DATA_W = 20;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DISP = 2'd1,
        SRC_HOST = 2'd2,
        SRC_ENG  = 2'd3
    } src_e;

    typedef struct packed {
        logic                 we;
        logic [CM_ADDR_W-1:0] addr;
        logic [CM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/cell_mem_arbiter_read_tag_pipe.sv
// Shift register carrying the source tag of each RAM access until its read
// data emerges; a synchronous clear drops everything in flight.
module read_tag_pipe
    import cell_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  src_e tag_in,
    output src_e tag_out
);

    src_e pipe_q [DEPTH];
    src_e pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= SRC_NONE;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/cell_mem_arbiter.sv
// Single-port cell RAM arbiter: display has priority up to a starvation cap,
// host and engine share the rest round-robin; read data is routed back by tag.
module cell_mem_arbiter
    import cell_mem_pkg::*;
#(
    parameter int ADDR_W       = CM_ADDR_W,
    parameter int DATA_W       = CM_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int MAX_STARVE   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_W = $clog2(MAX_STARVE + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

    src_e                gnt_src;
    src_e                rd_tag;
    src_e                ret_tag;
    src_e                rr_last_q, rr_last_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                other_req;
    mem_req_t            mem_q, mem_d;
    logic                disp_rvalid_q, disp_rvalid_d;
    logic                host_rvalid_q, host_rvalid_d;
    logic                eng_rvalid_q, eng_rvalid_d;
    logic [DATA_W-1:0]   disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0]   eng_rdata_q, eng_rdata_d;

    // Once capped, display only gets through when nobody else is asking.
    always_comb begin
        other_req = host_req | eng_req;
        gnt_src   = SRC_NONE;
        if (!reset) begin
            if (disp_req && (starve_q < STARVE_MAX || !other_req)) begin
                gnt_src = SRC_DISP;
            end else if (host_req && (!eng_req || rr_last_q == SRC_ENG)) begin
                gnt_src = SRC_HOST;
            end else if (eng_req) begin
                gnt_src = SRC_ENG;
            end
        end
    end

    assign disp_gnt = (gnt_src == SRC_DISP);
    assign host_gnt = (gnt_src == SRC_HOST);
    assign eng_gnt  = (gnt_src == SRC_ENG);

    always_comb begin
        starve_d  = starve_q;
        rr_last_d = rr_last_q;
        if (host_gnt || eng_gnt || !other_req) begin
            starve_d = '0;
        end else if (disp_gnt && starve_q < STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        if (host_gnt || eng_gnt) begin
            rr_last_d = gnt_src;
        end
    end

    // Idle cycles keep the last address/data on the bus, only we drops.
    always_comb begin
        mem_d    = mem_q;
        mem_d.we = 1'b0;
        rd_tag   = SRC_NONE;
        unique case (gnt_src)
            SRC_DISP: begin
                mem_d.addr  = disp_addr;
                mem_d.wdata = '0;
                rd_tag      = SRC_DISP;
            end
            SRC_HOST: begin
                mem_d.we    = host_we;
                mem_d.addr  = host_addr;
                mem_d.wdata = host_wdata;
                rd_tag      = host_we ? SRC_NONE : SRC_HOST;
            end
            SRC_ENG: begin
                mem_d.we    = eng_we;
                mem_d.addr  = eng_addr;
                mem_d.wdata = eng_wdata;
                rd_tag      = eng_we ? SRC_NONE : SRC_ENG;
            end
            default: ;
        endcase
    end

    read_tag_pipe #(
        .DEPTH (1 + READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (rd_tag),
        .tag_out (ret_tag)
    );

    always_comb begin
        disp_rvalid_d = (ret_tag == SRC_DISP);
        host_rvalid_d = (ret_tag == SRC_HOST);
        eng_rvalid_d  = (ret_tag == SRC_ENG);
        disp_rdata_d  = disp_rvalid_d ? mem_rdata : disp_rdata_q;
        host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
        eng_rdata_d   = eng_rvalid_d  ? mem_rdata : eng_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q      <= '0;
            rr_last_q     <= SRC_ENG;
            mem_q         <= '0;
            disp_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            eng_rvalid_q  <= 1'b0;
            disp_rdata_q  <= '0;
            host_rdata_q  <= '0;
            eng_rdata_q   <= '0;
        end else begin
            starve_q      <= starve_d;
            rr_last_q     <= rr_last_d;
            mem_q         <= mem_d;
            disp_rvalid_q <= disp_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            eng_rvalid_q  <= eng_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            host_rdata_q  <= host_rdata_d;
            eng_rdata_q   <= eng_rdata_d;
        end
    end

    assign mem_addr    = mem_q.addr;
    assign mem_we      = mem_q.we;
    assign mem_wdata   = mem_q.wdata;
    assign disp_rvalid = disp_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign eng_rvalid  = eng_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign host_rdata  = host_rdata_q;
    assign eng_rdata   = eng_rdata_q;

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Randomised bench for cell_mem_arbiter against a per-cycle behavioural model
// of grants, RAM issue and tagged read returns.
module tb_cell_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 20;
    localparam int RL = 1;
    localparam int MS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ram_init;
    logic          disp_req, disp_gnt, disp_rvalid;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          host_req, host_we, host_gnt, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          eng_req, eng_we, eng_gnt, eng_rvalid;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata, eng_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cell_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_STARVE(MS)
    ) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_gnt(eng_gnt),
        .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] dflt(input int i);
        if (i == 16) return 20'h0ABCD;
        return DW'((i * 32'h9E37) ^ 32'h3C3C5);
    endfunction

    // RAM with one cycle of read latency; aliased to 256 words
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= dflt(i);
        end else if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[7:0]];
    end

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    ret_t          ret_q[$];
    logic [DW-1:0] mdl_mem [0:255];
    int            starve, last_rr, cyc, g;
    int            n_chk, n_bad;
    int            p_disp, p_host, p_eng, wr_pct;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [2:0]    exp_rv;
    logic [DW-1:0] exp_rd [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_read(input int src, input logic [AW-1:0] a);
        ret_t r;
        r.src  = src;
        r.data = mdl_mem[a[7:0]];
        r.due  = cyc + 2 + RL;
        ret_q.push_back(r);
    endtask

    // One clock: check registered outputs and grants, advance the model.
    task automatic step();
        bit   others;
        ret_t r;
        @(negedge clk);
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        chk("disp_rvalid", 32'(disp_rvalid), 32'(exp_rv[0]));
        chk("host_rvalid", 32'(host_rvalid), 32'(exp_rv[1]));
        chk("eng_rvalid", 32'(eng_rvalid), 32'(exp_rv[2]));
        chk("disp_rdata", 32'(disp_rdata), 32'(exp_rd[0]));
        chk("host_rdata", 32'(host_rdata), 32'(exp_rd[1]));
        chk("eng_rdata", 32'(eng_rdata), 32'(exp_rd[2]));

        others = host_req || eng_req;
        g = 0;
        if (!reset) begin
            if (disp_req && starve < MS) g = 1;
            else if (disp_req && !others) g = 1;
            else if (host_req && eng_req) g = (last_rr == 3) ? 2 : 3;
            else if (host_req) g = 2;
            else if (eng_req) g = 3;
        end
        chk("disp_gnt", 32'(disp_gnt), 32'(g == 1));
        chk("host_gnt", 32'(host_gnt), 32'(g == 2));
        chk("eng_gnt", 32'(eng_gnt), 32'(g == 3));

        if (reset) begin
            starve = 0; last_rr = 3; ret_q.delete();
            exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_rv = '0;
            for (int i = 0; i < 3; i++) exp_rd[i] = '0;
        end else begin
            exp_we = 0;
            exp_rv = '0;
            if (g == 2 || g == 3 || !others) starve = 0;
            else if (g == 1 && starve < MS) starve++;
            if (g >= 2) last_rr = g;
            if (g == 1) begin
                exp_addr = disp_addr;
                model_read(1, disp_addr);
            end else if (g == 2) begin
                exp_addr = host_addr;
                if (host_we) begin
                    exp_we = 1; exp_wdata = host_wdata; mdl_mem[host_addr[7:0]] = host_wdata;
                end else model_read(2, host_addr);
            end else if (g == 3) begin
                exp_addr = eng_addr;
                if (eng_we) begin
                    exp_we = 1; exp_wdata = eng_wdata; mdl_mem[eng_addr[7:0]] = eng_wdata;
                end else model_read(3, eng_addr);
            end
            if (ret_q.size() > 0 && ret_q[0].due == cyc + 1) begin
                r = ret_q.pop_front();
                exp_rv[r.src-1] = 1'b1;
                exp_rd[r.src-1] = r.data;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // A requester keeps its request until granted, then maybe issues a new one.
    task automatic next_req();
        if (g == 1 || !disp_req) begin
            disp_req  = int'($urandom_range(99)) < p_disp;
            disp_addr = AW'($urandom);
        end
        if (g == 2 || !host_req) begin
            host_req   = int'($urandom_range(99)) < p_host;
            host_we    = int'($urandom_range(99)) < wr_pct;
            host_addr  = AW'($urandom);
            host_wdata = DW'($urandom);
        end
        if (g == 3 || !eng_req) begin
            eng_req   = int'($urandom_range(99)) < p_eng;
            eng_we    = int'($urandom_range(99)) < wr_pct;
            eng_addr  = AW'($urandom);
            eng_wdata = DW'($urandom);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            next_req();
        end
    endtask

    initial begin
        n_chk = 0; n_bad = 0; cyc = 0; g = 0;
        starve = 0; last_rr = 3;
        p_disp = 0; p_host = 0; p_eng = 0; wr_pct = 0;
        exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_rv = '0;
        for (int i = 0; i < 3; i++) exp_rd[i] = '0;
        for (int i = 0; i < 256; i++) mdl_mem[i] = dflt(i);
        reset = 1; ram_init = 1;
        disp_req = 0; disp_addr = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = '0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 0; ram_init = 0;

        // display read of 0x0010
        disp_req = 1; disp_addr = 16'h0010;
        run(6);

        // host and engine both reading continuously
        p_host = 100; p_eng = 100; wr_pct = 0;
        run(14);

        // display against engine: starvation cap
        p_host = 0; p_disp = 100;
        run(30);

        // display alone, then drain
        p_eng = 0;
        run(15);
        p_disp = 0;
        run(8);

        // host write
        host_req = 1; host_we = 1; host_addr = 16'h1234; host_wdata = 20'h5A5A5;
        run(6);

        // interleaved D(1), E(2), D(3)
        disp_req = 1; disp_addr = 16'h0001;
        step();
        disp_req = 0; eng_req = 1; eng_we = 0; eng_addr = 16'h0002;
        step();
        eng_req = 0; disp_req = 1; disp_addr = 16'h0003;
        step();
        disp_req = 0;
        run(6);

        // reset right after two reads; a request held through reset
        host_req = 1; host_we = 0; host_addr = 16'h0005;
        step();
        host_req = 0; eng_req = 1; eng_we = 0; eng_addr = 16'h0006;
        step();
        eng_req = 0; host_req = 1; host_we = 0; host_addr = 16'h0007;
        reset = 1;
        step();
        reset = 0;
        run(8);

        // random traffic
        p_disp = 40; p_host = 50; p_eng = 50; wr_pct = 30;
        run(1500);
        p_disp = 90; p_host = 70; p_eng = 70; wr_pct = 40;
        run(500);
        p_disp = 0; p_host = 0; p_eng = 0;
        run(12);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
